fir_sequencer: RTL and testbench
================================

// Module: fir_sequencer
// PURPOSE
//  Parametrised successor to the fixed 4-tap FIR control FSM. Sequences a shared register-file/ALU
//  datapath through N-tap coefficient loading and per-sample filtering: shift the sample line,
//  multiply-accumulate every tap with a per-tap add/subtract sign, then write the result to R0.
//  Sits between the input handshake (dr/lc) and the datapath; drives op/src1/src2/dest each cycle.
// PARAMETERS
//  NUM_TAPS   4        taps, 2..8
//  ADDR_W     5        register address width; 4+2*NUM_TAPS <= 2**ADDR_W
//  SIGN_MASK  4'b1010  bit k=1 -> tap k subtracted from acc, 0 -> added (width NUM_TAPS)
// PORTS
//  clk       in   1       clock, rising edge
//  n_rst     in   1       asynchronous reset, active low
//  dr        in   1       data ready: new sample on datapath input
//  lc        in   1       load coefficient: next coefficient on datapath input
//  overflow  in   1       datapath overflow for the op issued this cycle
//  cnt_up    out  1       one-cycle pulse per accepted sample
//  clear     out  1       one-cycle pulse at start of a coefficient load sequence
//  modwait   out  1       registered busy flag
//  op        out  3       000 NOP,001 COPY,010 LOAD_SAMPLE,011 LOAD_COEF,100 ADD,101 SUB,110 MUL
//  src1      out  ADDR_W  operand A address
//  src2      out  ADDR_W  operand B address
//  dest      out  ADDR_W  destination address
//  err       out  1       high while in ERROR
// BEHAVIOUR
//  Map: R0 output, R1 new sample, R2 product, R3 acc, S[k]=4+k, C[k]=4+NUM_TAPS+k.
//  Reset: state IDLE, tap/coef index 0, modwait 0; all combinational outputs 0 (op NOP).
//  States and outputs (unlisted fields 0):
//   IDLE: NOP. lc -> COEF (lc priority); else dr -> LOAD.
//   LOAD: LOAD_SAMPLE dest R1. dr=1 -> CLEAR; dr=0 -> ERROR.
//   CLEAR: SUB src1 R3 src2 R3 dest R3, cnt_up=1; -> SHIFT, k=NUM_TAPS-1.
//   SHIFT: k>0: COPY src1 S[k-1] dest S[k]; k=0: COPY src1 R1 dest S[0]; k-- ; after k=0 -> MUL, k=0.
//   MUL: MUL src1 S[k] src2 C[k] dest R2; -> ACC.
//   ACC: ADD/SUB (SIGN_MASK[k]) src1 R3 src2 R2 dest R3; k<NUM_TAPS-1 -> MUL,k++; else -> OUTPUT.
//   OUTPUT: COPY src1 R3 dest R0; -> IDLE.
//   COEF: LOAD_COEF dest C[ci]; clear=1 when ci=0; ci=NUM_TAPS-1 -> IDLE, ci=0; else -> CWAIT, ci++.
//   CWAIT: NOP; lc -> COEF.
//   ERROR: err=1, NOP; lc -> COEF with ci=0; else dr -> LOAD.
//  overflow sampled only in MUL and ACC; 1 -> ERROR next cycle, index reset to 0, acc not output.
//  modwait: flop, updated each edge to 1 iff next state is not IDLE/CWAIT/ERROR.
//  Sample latency: LOAD..OUTPUT = 3*NUM_TAPS+3 cycles (15 for N=4); modwait high throughout.
//  dr/lc while busy (LOAD excepted) ignored; upstream holds request until modwait=0.
//  dr and lc same cycle in IDLE/ERROR: coefficient load wins, sample dropped.
//  Reset mid-operation: immediate return to reset values; partial coefficient load abandoned,
//   next lc restarts at C[0].
// CONFIGURATION
//  FIR_ERR_COUNT_EN defined: extra port err_count out 8 = ERROR entries since reset,
//   saturating at 255, increments on the edge entering ERROR, reset 0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  Reset mid-SHIFT -> next cycle IDLE, all outputs 0, modwait 0, next lc writes C[0] with clear=1.
//  4 lc pulses gapped 3 cycles -> dest 8,9,10,11 op 011, clear only on first, modwait 1 one cycle each.
//  dr held 2 cycles, N=4, SIGN_MASK 1010 -> 15 busy cycles, ACC ops ADD,SUB,ADD,SUB, final COPY 3->0.
//  dr drops after 1 cycle -> LOAD then ERROR, err=1, modwait=0; dr again -> LOAD, err=0.
//  overflow=1 during second MUL -> ERROR next cycle, no OUTPUT COPY, err_count 0->1 (macro on).
//  NUM_TAPS=8, ADDR_W=5 -> SHIFT dests 11..4, MUL src2 12..19, latency 27 cycles.

Source files
------------

// File: rtl/fir_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sequencer
//   Control FSM for an N-tap FIR filter built on a shared register-file/ALU
//   datapath. It loads N coefficients one handshake at a time, and for each
//   sample it:
//     - shifts the sample delay line,
//     - multiply-accumulates every tap with a per-tap add/subtract sign,
//     - copies the accumulator to R0.
//   The datapath micro-op (op/src1/src2/dest) is decoded from the current
//   state and tap index.
//
//   Register map: R0 output, R1 new sample, R2 product, R3 accumulator,
//                 S[k] = 4+k (sample line), C[k] = 4+NUM_TAPS+k (coefficients)
//
// Parameters
//   NUM_TAPS   taps, 2..8
//   ADDR_W     register address width, needs 4+2*NUM_TAPS <= 2**ADDR_W
//   SIGN_MASK  bit k set -> tap k product is subtracted from the accumulator
//
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous reset, active low
//   dr         in   data ready (new sample on datapath input)
//   lc         in   load coefficient (next coefficient on datapath input)
//   overflow   in   datapath overflow for the op issued this cycle
//   cnt_up     out  one-cycle pulse per accepted sample
//   clear      out  one-cycle pulse at the first coefficient of a load sequence
//   modwait    out  registered busy flag
//   op         out  000 NOP, 001 COPY, 010 LOAD_SAMPLE, 011 LOAD_COEF,
//                   100 ADD, 101 SUB, 110 MUL
//   src1/src2  out  operand addresses
//   dest       out  destination address
//   err        out  high while in ERROR
//   err_count  out  (only with FIR_ERR_COUNT_EN) saturating count of ERROR
//                   entries since reset
//
// Build option
//   FIR_ERR_COUNT_EN : adds the err_count port and its counter.
// -----------------------------------------------------------------------------
module fir_sequencer #(
    parameter int                  NUM_TAPS  = 4,
    parameter int                  ADDR_W    = 5,
    parameter logic [NUM_TAPS-1:0] SIGN_MASK = 4'b1010
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              dr,
    input  logic              lc,
    input  logic              overflow,
    output logic              cnt_up,
    output logic              clear,
    output logic              modwait,
    output logic [2:0]        op,
    output logic [ADDR_W-1:0] src1,
    output logic [ADDR_W-1:0] src2,
    output logic [ADDR_W-1:0] dest,
    output logic              err
`ifdef FIR_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int            KW   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [KW-1:0] KMAX = KW'(NUM_TAPS - 1);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_COPY = 3'b001;
    localparam logic [2:0] OP_LDS  = 3'b010;
    localparam logic [2:0] OP_LDC  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    localparam logic [ADDR_W-1:0] R_OUT  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] R_SMP  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] R_PROD = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] R_ACC  = ADDR_W'(3);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_SHIFT,
        S_MUL,
        S_ACC,
        S_OUT,
        S_COEF,
        S_CWAIT,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;     // tap index for SHIFT/MUL/ACC
    logic [KW-1:0] ci_q, ci_d;   // coefficient index for COEF
    logic          modwait_q, modwait_d;

    function automatic logic [ADDR_W-1:0] s_addr(input logic [KW-1:0] i);
        return ADDR_W'(4 + int'(i));
    endfunction

    function automatic logic [ADDR_W-1:0] c_addr(input logic [KW-1:0] i);
        return ADDR_W'(4 + NUM_TAPS + int'(i));
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ci_d    = ci_q;
        unique case (state_q)
            S_IDLE: begin
                // Coefficient load wins when both requests arrive together.
                if (lc)      state_d = S_COEF;
                else if (dr) state_d = S_LOAD;
            end
            S_LOAD: begin
                // The sample must still be valid one cycle after LOAD was entered.
                state_d = dr ? S_CLEAR : S_ERR;
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
                k_d     = KMAX;
            end
            S_SHIFT: begin
                // Shifting walks from the oldest tap down, so no slot is
                // overwritten before it has been copied on.
                if (k_q == '0) state_d = S_MUL;
                else           k_d     = k_q - KW'(1);
            end
            S_MUL: begin
                if (overflow) begin
                    state_d = S_ERR;
                    k_d     = '0;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (overflow) begin
                    state_d = S_ERR;
                    k_d     = '0;
                end else if (k_q != KMAX) begin
                    state_d = S_MUL;
                    k_d     = k_q + KW'(1);
                end else begin
                    state_d = S_OUT;
                    k_d     = '0;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            S_COEF: begin
                if (ci_q == KMAX) begin
                    state_d = S_IDLE;
                    ci_d    = '0;
                end else begin
                    state_d = S_CWAIT;
                    ci_d    = ci_q + KW'(1);
                end
            end
            S_CWAIT: begin
                // Mid coefficient load: only the next lc is of interest.
                if (lc) state_d = S_COEF;
            end
            S_ERR: begin
                if (lc) begin
                    state_d = S_COEF;
                    ci_d    = '0;
                end else if (dr) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
                ci_d    = '0;
            end
        endcase

        // Busy whenever the FSM will be in a state that cannot take a request.
        modwait_d = !(state_d inside {S_IDLE, S_CWAIT, S_ERR});
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            ci_q      <= '0;
            modwait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ci_q      <= ci_d;
            modwait_q <= modwait_d;
        end
    end

    assign modwait = modwait_q;

`ifdef FIR_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Counts entries only: lingering in ERROR does not add to the count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_cnt_q <= '0;
        end else if (state_d == S_ERR && state_q != S_ERR && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Datapath command decode (function of current state and indices)
    // ------------------------------------------------------------------
    always_comb begin
        cnt_up = 1'b0;
        clear  = 1'b0;
        err    = 1'b0;
        op     = OP_NOP;
        src1   = '0;
        src2   = '0;
        dest   = '0;
        unique case (state_q)
            S_LOAD: begin
                op   = OP_LDS;
                dest = R_SMP;
            end
            S_CLEAR: begin
                // acc - acc zeroes the accumulator without a dedicated op.
                op     = OP_SUB;
                src1   = R_ACC;
                src2   = R_ACC;
                dest   = R_ACC;
                cnt_up = 1'b1;
            end
            S_SHIFT: begin
                op   = OP_COPY;
                src1 = (k_q == '0) ? R_SMP : s_addr(k_q - KW'(1));
                dest = s_addr(k_q);
            end
            S_MUL: begin
                op   = OP_MUL;
                src1 = s_addr(k_q);
                src2 = c_addr(k_q);
                dest = R_PROD;
            end
            S_ACC: begin
                op   = SIGN_MASK[k_q] ? OP_SUB : OP_ADD;
                src1 = R_ACC;
                src2 = R_PROD;
                dest = R_ACC;
            end
            S_OUT: begin
                op   = OP_COPY;
                src1 = R_ACC;
                dest = R_OUT;
            end
            S_COEF: begin
                op    = OP_LDC;
                dest  = c_addr(ci_q);
                clear = (ci_q == '0);
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_sequencer
//   Two sequencers share clock and reset: u4 (4 taps, mask 1010) and
//   u8 (8 taps, mask 01101001). Expected command streams are generated from
//   the register map and the sample/coefficient procedures, compared on the
//   falling edge. A randomized phase mixes coefficient loads, normal samples,
//   dropped samples and overflows, tracked by a small per-DUT model
//   (coefficient index, error flag, error count).
// -----------------------------------------------------------------------------
module tb_fir_sequencer;

    typedef struct packed {
        logic       err;
        logic       cnt_up;
        logic       clear;
        logic       modwait;
        logic [2:0] op;
        logic [4:0] src1;
        logic [4:0] src2;
        logic [4:0] dest;
    } obs_t;

    localparam logic [2:0] NOP = 3'd0, COPY = 3'd1, LDS = 3'd2, LDC = 3'd3,
                           ADD = 3'd4, SUB = 3'd5, MUL = 3'd6;
    localparam logic [3:0] MASK4 = 4'b1010;
    localparam logic [7:0] MASK8 = 8'b0110_1001;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [1:0] dr = '0, lc = '0, ov = '0;

    logic       cu0, cl0, mw0, er0, cu1, cl1, mw1, er1;
    logic [2:0] op0, op1;
    logic [4:0] a0, b0, d0, a1, b1, d1;
`ifdef FIR_ERR_COUNT_EN
    logic [7:0] ec0, ec1;
`endif

    obs_t ob0, ob1;
    assign ob0 = {er0, cu0, cl0, mw0, op0, a0, b0, d0};
    assign ob1 = {er1, cu1, cl1, mw1, op1, a1, b1, d1};

    fir_sequencer #(.NUM_TAPS(4), .ADDR_W(5), .SIGN_MASK(MASK4)) u4 (
        .clk(clk), .n_rst(n_rst), .dr(dr[0]), .lc(lc[0]), .overflow(ov[0]),
        .cnt_up(cu0), .clear(cl0), .modwait(mw0), .op(op0),
        .src1(a0), .src2(b0), .dest(d0), .err(er0)
`ifdef FIR_ERR_COUNT_EN
        , .err_count(ec0)
`endif
    );

    fir_sequencer #(.NUM_TAPS(8), .ADDR_W(5), .SIGN_MASK(MASK8)) u8 (
        .clk(clk), .n_rst(n_rst), .dr(dr[1]), .lc(lc[1]), .overflow(ov[1]),
        .cnt_up(cu1), .clear(cl1), .modwait(mw1), .op(op1),
        .src1(a1), .src2(b1), .dest(d1), .err(er1)
`ifdef FIR_ERR_COUNT_EN
        , .err_count(ec1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model state, per DUT
    int mdl_ci  [2];
    bit mdl_err [2];
    int mdl_ecnt[2];

    function automatic obs_t mk(input logic [2:0] o, input int s1, input int s2, input int d,
                                input bit cu, input bit cl, input bit mw, input bit er);
        obs_t r;
        r.err = er; r.cnt_up = cu; r.clear = cl; r.modwait = mw;
        r.op = o; r.src1 = 5'(s1); r.src2 = 5'(s2); r.dest = 5'(d);
        return r;
    endfunction

    function automatic int ntaps(input int sel);
        return (sel != 0) ? 8 : 4;
    endfunction

    function automatic bit sgn(input int sel, input int k);
        return (sel != 0) ? MASK8[k] : MASK4[k];
    endfunction

    task automatic chk(input int sel, input obs_t e, input string tag);
        obs_t o;
        o = (sel != 0) ? ob1 : ob0;
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s dut%0d: got %h expected %h", tag, sel, o, e);
        end
    endtask

    task automatic chk_ecnt(input int sel, input string tag);
`ifdef FIR_ERR_COUNT_EN
        logic [7:0] o;
        o = (sel != 0) ? ec1 : ec0;
        checks++;
        assert (o === 8'(mdl_ecnt[sel])) else begin
            fails++;
            $error("FAIL %s dut%0d err_count: got %0d expected %0d", tag, sel, o, mdl_ecnt[sel]);
        end
`endif
    endtask

    // Idle-like states (IDLE, CWAIT, ERROR) issue NOP with modwait low.
    function automatic obs_t idle_exp(input int sel);
        return mk(NOP, 0, 0, 0, 0, 0, 0, mdl_err[sel]);
    endfunction

    task automatic gap(input int sel, input int n);
        repeat (n) begin
            @(negedge clk);
            chk(sel, idle_exp(sel), "gap");
        end
    endtask

    // One lc handshake; with_dr also raises dr in the same cycle.
    task automatic do_coef(input int sel, input bit with_dr);
        @(negedge clk);
        ov[sel] = 1'b0;
        chk(sel, idle_exp(sel), "coef_pre");
        lc[sel] = 1'b1;
        dr[sel] = with_dr;
        @(negedge clk);
        if (mdl_err[sel]) mdl_ci[sel] = 0;
        chk(sel, mk(LDC, 0, 0, 4 + ntaps(sel) + mdl_ci[sel], 0, mdl_ci[sel] == 0, 1, 0), "coef");
        lc[sel] = 1'b0;
        dr[sel] = 1'b0;
        mdl_err[sel] = 1'b0;
        mdl_ci[sel]  = (mdl_ci[sel] == ntaps(sel) - 1) ? 0 : mdl_ci[sel] + 1;
    endtask

    // One sample. hold=0 drops dr after the LOAD cycle; ovp>=0 raises
    // overflow in that cycle of the command stream (must be a MUL/ACC slot).
    task automatic do_sample(input int sel, input bit hold, input int ovp);
        obs_t q[$];
        int   n, len, busy;
        n = ntaps(sel);
        busy = 0;
        q.push_back(mk(LDS, 0, 0, 1, 0, 0, 1, 0));
        q.push_back(mk(SUB, 3, 3, 3, 1, 0, 1, 0));
        for (int k = n - 1; k >= 0; k--)
            q.push_back(mk(COPY, (k > 0) ? 4 + k - 1 : 1, 0, 4 + k, 0, 0, 1, 0));
        for (int k = 0; k < n; k++) begin
            q.push_back(mk(MUL, 4 + k, 4 + n + k, 2, 0, 0, 1, 0));
            q.push_back(mk(sgn(sel, k) ? SUB : ADD, 3, 2, 3, 0, 0, 1, 0));
        end
        q.push_back(mk(COPY, 3, 0, 0, 0, 0, 1, 0));
        len = !hold ? 1 : (ovp >= 0 ? ovp + 1 : q.size());

        @(negedge clk);
        ov[sel] = 1'b0;
        chk(sel, idle_exp(sel), "smp_pre");
        dr[sel] = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            busy += int'((sel != 0) ? mw1 : mw0);
            chk(sel, q[i], $sformatf("smp_step%0d", i));
            dr[sel] = (i == 0) && hold;
            ov[sel] = (i == ovp);
        end
        if (hold && ovp < 0) begin
            checks++;
            assert (busy == 3 * n + 3) else begin
                fails++;
                $error("FAIL latency dut%0d: got %0d expected %0d", sel, busy, 3 * n + 3);
            end
            mdl_err[sel] = 1'b0;
        end else begin
            mdl_err[sel] = 1'b1;
            if (mdl_ecnt[sel] < 255) mdl_ecnt[sel]++;
        end
        @(negedge clk);
        ov[sel] = 1'b0;
        dr[sel] = 1'b0;
        chk(sel, idle_exp(sel), "smp_post");
        chk_ecnt(sel, "smp_post");
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mdl_ci[s] = 0; mdl_err[s] = 1'b0; mdl_ecnt[s] = 0;
        end
    endtask

    // Asynchronous reset pulse well away from the rising edge.
    task automatic pulse_reset(input string tag);
        #1 n_rst = 1'b0;
        dr = '0; lc = '0; ov = '0;
        model_reset();
        #1;
        chk(0, mk(NOP, 0, 0, 0, 0, 0, 0, 0), tag);
        chk(1, mk(NOP, 0, 0, 0, 0, 0, 0, 0), tag);
        chk_ecnt(0, tag);
        #1 n_rst = 1'b1;
    endtask

    initial begin
        int r, sel;
        model_reset();

        // Reset state
        @(negedge clk);
        pulse_reset("reset");

        // Four coefficient loads, three idle cycles apart
        for (int i = 0; i < 4; i++) begin
            do_coef(0, 1'b0);
            gap(0, 3);
        end

        // Full sample, then dropped dr -> ERROR, then recovery from ERROR
        do_sample(0, 1'b1, -1);
        do_sample(0, 1'b0, -1);
        do_sample(0, 1'b1, -1);

        // Overflow during the second MUL (stream slot 4+2+2)
        do_sample(0, 1'b1, 8);

        // dr+lc together from ERROR, then from IDLE: coefficient wins
        do_coef(0, 1'b1);
        for (int i = 0; i < 3; i++) do_coef(0, 1'b0);
        do_coef(0, 1'b1);
        for (int i = 0; i < 3; i++) do_coef(0, 1'b0);

        // Partial coefficient load abandoned by reset, restarts at C[0]
        do_coef(0, 1'b0);
        do_coef(0, 1'b0);
        @(negedge clk);
        pulse_reset("reset_coef");
        for (int i = 0; i < 4; i++) do_coef(0, 1'b0);

        // Reset in the middle of SHIFT
        @(negedge clk);
        chk(0, idle_exp(0), "rs_pre");
        dr[0] = 1'b1;
        @(negedge clk);
        chk(0, mk(LDS, 0, 0, 1, 0, 0, 1, 0), "rs_load");
        @(negedge clk);
        dr[0] = 1'b0;
        chk(0, mk(SUB, 3, 3, 3, 1, 0, 1, 0), "rs_clear");
        @(negedge clk);
        chk(0, mk(COPY, 6, 0, 7, 0, 0, 1, 0), "rs_shift");
        pulse_reset("reset_shift");
        do_coef(0, 1'b0);
        for (int i = 0; i < 3; i++) do_coef(0, 1'b0);

        // Eight-tap instance: full sample and an overflow in ACC
        do_sample(1, 1'b1, -1);
        do_sample(1, 1'b1, 10 + 2 * int'($urandom_range(7, 0)) + 1);
        do_sample(1, 1'b1, -1);

        // Randomized mix on both instances
        for (int it = 0; it < 60; it++) begin
            sel = int'($urandom_range(1, 0));
            r   = int'($urandom_range(9, 0));
            if (mdl_ci[sel] != 0 || r < 3) begin
                do_coef(sel, 1'($urandom_range(1, 0)));
            end else if (r == 3) begin
                do_sample(sel, 1'b0, -1);
            end else if (r < 6) begin
                do_sample(sel, 1'b1,
                          ntaps(sel) + 2 + int'($urandom_range(2 * ntaps(sel) - 1, 0)));
            end else begin
                do_sample(sel, 1'b1, -1);
            end
            gap(sel, int'($urandom_range(3, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
